// File: rtl/mc_maindec.sv
// mc_maindec: multicycle main decoder. A Moore FSM steps each instruction
// through fetch, decode, execute, memory and writeback so that the ALU and
// memory can be shared across cycles. It adds a memory wait handshake, a
// bounded FPU start/done handshake, a sticky illegal-instruction trap and a
// retired-instruction counter.
module mc_maindec #(
  parameter bit MEM_HANDSHAKE = 1'b1,  // 0: mem_ready ignored, treated as 1
  parameter int FPU_TIMEOUT   = 64,    // max FPEXEC cycles, must be >= 2
  parameter int CNT_W         = 32     // instret width
) (
  input  logic             clk,
  input  logic             reset,       // synchronous, active-low
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  input  logic             fpu_done,
  output logic             pcwrite,
  output logic             iord,
  output logic             irwrite,
  output logic             memwrite,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [3:0]       aluop,
  output logic             branch,
  output logic             ne,
  output logic [1:0]       pcsrc,
  output logic             fpu_start,
  output logic [3:0]       fpu_control,
  output logic             fp_regwrite,
  output logic             illegal,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret
);

  localparam int TIMER_W = $clog2(FPU_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FPU_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP   = 4'd11,
    S_FPEXEC = 4'd12, S_FPWB   = 4'd13, S_TRAP   = 4'd14
  } state_t;

  state_t               state_q, state_d, out_state;
  logic [5:0]           op_q, funct_q;
  logic [TIMER_W-1:0]   timer_q;
  logic                 illegal_q;
  logic [CNT_W-1:0]     instret_q;
  logic                 rdy;
  logic                 retire;

  // Only these FP functions are implemented; anything else traps in DECODE.
  function automatic logic fp_funct_legal(input logic [5:0] f);
    case (f)
      6'b000000, 6'b000001, 6'b000010,
      6'b000011, 6'b000101, 6'b000111: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // Next-state decode and retirement detection.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          6'b100011, 6'b100001, 6'b100000, 6'b100100, 6'b100101,
          6'b101011, 6'b101001, 6'b101000:                        state_d = S_MEMADR;
          6'b000000:                                              state_d = S_EXEC;
          6'b000100, 6'b000101:                                   state_d = S_BRANCH;
          6'b001000, 6'b001001, 6'b001101, 6'b001100, 6'b001010: state_d = S_IEXEC;
          6'b000010:                                              state_d = S_JUMP;
          6'b010001: state_d = fp_funct_legal(funct) ? S_FPEXEC : S_TRAP;
          default:                                                state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = op_q[3] ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (rdy) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (rdy) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_FPEXEC: begin
        // fpu_done wins over a timeout in the same cycle
        if (fpu_done)                  state_d = S_FPWB;
        else if (timer_q == TIMER_LAST) state_d = S_TRAP;
      end
      S_FPWB:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
    retire = (state_d == S_FETCH) &&
             (state_q inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_IWB, S_JUMP, S_FPWB});
  end

  // State, FPU timer, sticky trap flag and retired-instruction counter.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q   <= S_FETCH;
      timer_q   <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= (state_q == S_FPEXEC) ? timer_q + 1'b1 : '0;
      illegal_q <= illegal_q | (state_d == S_TRAP);
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  // Capture the instruction fields in DECODE; later states decode from these.
  always_ff @(posedge clk) begin
    // NOTE: no reset here: op_q/funct_q are only read in states entered
    // through DECODE, which always loads them first.
    if (state_q == S_DECODE) begin
      op_q    <= op;
      funct_q <= funct;
    end
  end

  // While reset is held the outputs look like FETCH regardless of state_q.
  assign out_state = reset ? state_q : S_FETCH;

  // Moore output decode from the (reset-masked) current state.
  always_comb begin
    pcwrite     = 1'b0;
    iord        = 1'b0;
    irwrite     = 1'b0;
    memwrite    = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 4'b0000;
    branch      = 1'b0;
    ne          = 1'b0;
    pcsrc       = 2'b00;
    fpu_start   = 1'b0;
    fpu_control = 4'b0000;
    fp_regwrite = 1'b0;
    case (out_state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = rdy;
        pcwrite = rdy;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:  iord = 1'b1;
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 4'b1111;   // ALU decoder resolves the operation from funct
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 4'b0001;
        branch  = 1'b1;
        pcsrc   = 2'b01;
        ne      = op_q[0];
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op_q)
          6'b001101: aluop = 4'b0011;  // ORI
          6'b001100: aluop = 4'b0111;  // ANDI
          6'b001010: aluop = 4'b0110;  // SLTI
          default:   aluop = 4'b0000;  // ADDI / ADDIU
        endcase
      end
      S_IWB:    regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      S_FPEXEC: begin
        fpu_start = (timer_q == '0);   // first FPEXEC cycle only
        case (funct_q)
          6'b000001: fpu_control = 4'b0001;
          6'b000010: fpu_control = 4'b0010;
          6'b000011: fpu_control = 4'b0011;
          6'b000101: fpu_control = 4'b0100;
          6'b000111: fpu_control = 4'b0101;
          default:   fpu_control = 4'b0000;
        endcase
      end
      S_FPWB:   fp_regwrite = 1'b1;
      default:  ;
    endcase
  end

  assign illegal    = reset & illegal_q;
  assign instr_done = reset & retire;
  assign state      = out_state;
  assign instret    = reset ? instret_q : '0;

endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec: cycle-accurate scoreboard bench for the multicycle decoder.
// The driver pushes the expected state/controls for every cycle it drives;
// a negedge monitor pops each entry and compares it with the DUT.
module tb_mc_maindec;

  localparam int TO = 8;

  localparam logic [3:0] FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
                         MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB = 4'd7,
                         BRANCH = 4'd8,  IEXEC  = 4'd9,  IWB    = 4'd10, JUMP  = 4'd11,
                         FPEXEC = 4'd12, FPWB   = 4'd13, TRAP   = 4'd14;

  typedef struct packed {
    logic       pcwrite;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluop;
    logic       branch;
    logic       ne;
    logic [1:0] pcsrc;
    logic       fpu_start;
    logic [3:0] fpu_control;
    logic       fp_regwrite;
    logic       illegal;
    logic       instr_done;
  } ctrl_t;

  typedef struct packed {
    logic        skip;
    logic [3:0]  state;
    ctrl_t       ctrl;
    logic [31:0] instret;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  op, funct;
  logic        mem_ready, fpu_done;
  logic        pcwrite, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0]  alusrcb;
  logic [3:0]  aluop;
  logic        branch, ne;
  logic [1:0]  pcsrc;
  logic        fpu_start;
  logic [3:0]  fpu_control;
  logic        fp_regwrite, illegal;
  logic [3:0]  state;
  logic        instr_done;
  logic [31:0] instret;

  ctrl_t       got_ctrl;
  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_instret;
  logic [5:0]  t_op, t_funct;
  string       cur_name = "reset";

  mc_maindec #(
    .MEM_HANDSHAKE(1'b1),
    .FPU_TIMEOUT  (TO),
    .CNT_W        (32)
  ) dut (
    .clk        (clk),
    .reset      (reset_n),
    .op         (op),
    .funct      (funct),
    .mem_ready  (mem_ready),
    .fpu_done   (fpu_done),
    .pcwrite    (pcwrite),
    .iord       (iord),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .branch     (branch),
    .ne         (ne),
    .pcsrc      (pcsrc),
    .fpu_start  (fpu_start),
    .fpu_control(fpu_control),
    .fp_regwrite(fp_regwrite),
    .illegal    (illegal),
    .state      (state),
    .instr_done (instr_done),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  assign got_ctrl = {pcwrite, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
                     alusrcb, aluop, branch, ne, pcsrc, fpu_start, fpu_control,
                     fp_regwrite, illegal, instr_done};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference output table: what each state drives, given the instruction in flight.
  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic rdy, input logic first);
    ctrl_t c = '0;
    case (st)
      FETCH:  begin c.alusrcb = 2'b01; c.irwrite = rdy; c.pcwrite = rdy; end
      DECODE: c.alusrcb = 2'b11;
      MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:  c.iord = 1'b1;
      MEMWB:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      MEMWR:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
      EXEC:   begin c.alusrca = 1'b1; c.aluop = 4'b1111; end
      ALUWB:  begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      BRANCH: begin
        c.alusrca = 1'b1; c.aluop = 4'b0001; c.branch = 1'b1;
        c.pcsrc = 2'b01; c.ne = t_op[0];
      end
      IEXEC:  begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10;
        case (t_op)
          6'b001101: c.aluop = 4'b0011;
          6'b001100: c.aluop = 4'b0111;
          6'b001010: c.aluop = 4'b0110;
          default:   c.aluop = 4'b0000;
        endcase
      end
      IWB:    c.regwrite = 1'b1;
      JUMP:   begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      FPEXEC: begin
        c.fpu_start = first;
        case (t_funct)
          6'b000001: c.fpu_control = 4'b0001;
          6'b000010: c.fpu_control = 4'b0010;
          6'b000011: c.fpu_control = 4'b0011;
          6'b000101: c.fpu_control = 4'b0100;
          6'b000111: c.fpu_control = 4'b0101;
          default:   c.fpu_control = 4'b0000;
        endcase
      end
      FPWB:   c.fp_regwrite = 1'b1;
      TRAP:   c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // Instruction class: 0 load, 1 store, 2 R-type, 3 branch, 4 imm, 5 jump, 6 FP, 7 trap.
  function automatic int cls(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b100011, 6'b100001, 6'b100000, 6'b100100, 6'b100101: return 0;
      6'b101011, 6'b101001, 6'b101000:                        return 1;
      6'b000000:                                              return 2;
      6'b000100, 6'b000101:                                   return 3;
      6'b001000, 6'b001001, 6'b001101, 6'b001100, 6'b001010: return 4;
      6'b000010:                                              return 5;
      6'b010001: return (f inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd5, 6'd7}) ? 6 : 7;
      default:                                                return 7;
    endcase
  endfunction

  // One clock cycle: drive inputs, push the expectation, advance past the edge.
  task automatic cyc(input logic [3:0] st, input logic mr, input logic fd,
                     input logic done, input logic first, input logic skip);
    exp_t e;
    mem_ready = mr;
    fpu_done  = fd;
    e.skip    = skip;
    e.state   = st;
    e.ctrl    = exp_ctrl(st, mr, first);
    e.ctrl.instr_done = done;
    e.instret = exp_instret;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (done) exp_instret = exp_instret + 32'd1;
  endtask

  // Full instruction; op/funct are scrambled after DECODE to prove they are registered.
  task automatic do_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                          input int fstall, input int mstall, input int fdelay);
    int   c;
    logic hit;
    hit      = 1'b0;
    cur_name = name;
    t_op     = o;
    t_funct  = f;
    c        = cls(o, f);
    repeat (fstall) cyc(FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    op = o; funct = f;
    cyc(DECODE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    op = 6'h3f; funct = 6'h3f;
    case (c)
      0: begin
        cyc(MEMADR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (mstall) cyc(MEMRD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(MEMRD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(MEMWB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      1: begin
        cyc(MEMADR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (mstall) cyc(MEMWR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(MEMWR, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      2: begin
        cyc(EXEC,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(ALUWB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      3: cyc(BRANCH, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      4: begin
        cyc(IEXEC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(IWB,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      5: cyc(JUMP, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      6: begin
        for (int k = 0; k < TO; k++) begin
          if (!hit) begin
            hit = (k == fdelay);
            cyc(FPEXEC, 1'b1, hit, 1'b0, (k == 0), 1'b0);
          end
        end
        if (hit) cyc(FPWB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        else     cyc(TRAP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      default: cyc(TRAP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endcase
  endtask

  // Two cycles of reset; the first is not compared (state still pre-reset).
  task automatic apply_reset();
    reset_n = 1'b0;
    cyc(FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_instret = '0;
    cyc(FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check({cur_name, " rst state"},    64'(state),    64'd0);
    check({cur_name, " rst memwrite"}, 64'(memwrite), 64'd0);
    check({cur_name, " rst instret"},  64'(instret),  64'd0);
    check({cur_name, " rst illegal"},  64'(illegal),  64'd0);
    reset_n = 1'b1;
  endtask

  task automatic trap_hold(input int n);
    repeat (n) cyc(TRAP, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check({cur_name, " illegal sticky"}, 64'(illegal), 64'd1);
    check({cur_name, " trap state"},     64'(state),   64'(TRAP));
  endtask

  // Scoreboard monitor: compare one expected entry per cycle, away from posedge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!e.skip) begin
        check({cur_name, " state"},   64'(state),    64'(e.state));
        check({cur_name, " ctrl"},    64'(got_ctrl), 64'(e.ctrl));
        check({cur_name, " instret"}, 64'(instret),  64'(e.instret));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; op = '0; funct = '0; mem_ready = 1'b0; fpu_done = 1'b0;
    exp_instret = '0; t_op = '0; t_funct = '0;
    @(posedge clk);
    #1;
    apply_reset();

    // Load with fetch and memory wait states.
    do_instr("lw_stall", 6'b100011, 6'b000000, 3, 2, -1);

    // Reset asserted in the middle of a stalled store.
    cur_name = "sw_reset";
    t_op = 6'b101011; t_funct = '0;
    cyc(FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    op = 6'b101011;
    cyc(DECODE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    op = 6'h3f;
    cyc(MEMADR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(MEMWR,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_reset();

    // Back-to-back mix with memory always ready.
    do_instr("rtype", 6'b000000, 6'b100000, 0, 0, -1);
    do_instr("addi",  6'b001000, 6'b000000, 0, 0, -1);
    do_instr("beq",   6'b000100, 6'b000000, 0, 0, -1);
    do_instr("bne",   6'b000101, 6'b000000, 0, 0, -1);
    do_instr("j",     6'b000010, 6'b000000, 0, 0, -1);
    check("instret_after_5", 64'(instret), 64'd5);

    do_instr("ori",   6'b001101, 6'b000000, 0, 0, -1);
    do_instr("andi",  6'b001100, 6'b000000, 0, 0, -1);
    do_instr("slti",  6'b001010, 6'b000000, 0, 0, -1);
    do_instr("sw_wait", 6'b101011, 6'b000000, 1, 2, -1);
    do_instr("lbu",   6'b100100, 6'b000000, 0, 0, -1);

    // FP ops: done after 5 cycles, and done in the very first cycle.
    do_instr("fdiv",  6'b010001, 6'b000011, 0, 0, 5);
    do_instr("fneg",  6'b010001, 6'b000111, 0, 0, 0);
    do_instr("fdone_last", 6'b010001, 6'b000010, 0, 0, TO - 1);

    // FP timeout traps after TO cycles in FPEXEC.
    do_instr("ftimeout", 6'b010001, 6'b000000, 0, 0, -1);
    trap_hold(3);
    apply_reset();

    // Undefined opcode and undefined FP function trap from DECODE.
    do_instr("bad_op", 6'b111111, 6'b000000, 0, 0, -1);
    trap_hold(3);
    apply_reset();
    do_instr("bad_fp_funct", 6'b010001, 6'b000100, 0, 0, -1);
    trap_hold(2);
    apply_reset();

    do_instr("addiu", 6'b001001, 6'b000000, 0, 0, -1);
    check("instret_final", 64'(instret), 64'd1);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_maindec.md
Name: mc_maindec

Overview:
Multicycle successor to the single-cycle main decoder. A Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, so the ALU and memory are shared across cycles. It adds a memory wait handshake, a bounded FPU start/done handshake with timeout, a sticky illegal-instruction trap and a retired-instruction counter. It sits between the instruction register and the shared multicycle datapath.

Parameters:
MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready; 0: mem_ready is ignored and treated as 1
FPU_TIMEOUT, 64, maximum cycles spent in FPEXEC waiting for fpu_done before trapping (must be ≥2)
CNT_W, 32, width of the instret counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
op  in  6  instruction opcode (IR[31:26])
funct  in  6  function field (IR[5:0])
mem_ready  in  1  memory access complete this cycle
fpu_done  in  1  FPU result valid
pcwrite  out  1  PC write enable
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
irwrite  out  1  instruction register write enable
memwrite  out  1  data memory write
regwrite, regdst, memtoreg  out  1 each  GPR writeback controls
alusrca  out  1  0 = PC, 1 = rs
alusrcb  out  2  00 = rt, 01 = constant 4, 10 = immediate, 11 = immediate shifted left 2
aluop  out  4  ALU operation class
branch, ne  out  1 each  conditional PC update; ne = 1 selects branch-not-equal
pcsrc  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
fpu_start  out  1  one-cycle FPU launch pulse
fpu_control  out  4  FPU operation
fp_regwrite  out  1  FP register file write
illegal  out  1  sticky trap flag
state  out  4  current state, for debug
instr_done  out  1  instruction retires this cycle
instret  out  CNT_W  retired-instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, FPEXEC=12, FPWB=13, TRAP=14.
- Reset (reset = 0 at a clk edge): state = FETCH, instret = 0, illegal = 0, FPU timer = 0. Reset overrides every other input, including in the middle of an instruction. During reset all outputs are 0 except those FETCH asserts combinationally (listed below).
- Output model: all outputs are Moore outputs decoded from state. Exceptions: pcwrite and irwrite in FETCH, which are gated by rdy; fpu_start; and the ne and aluop values taken from the registered op. Any output not listed for a state is 0.
- rdy = mem_ready when MEM_HANDSHAKE = 1; rdy = 1 when MEM_HANDSHAKE = 0.
- FETCH:
  - Outputs: iord = 0, alusrca = 0, alusrcb = 01, aluop = 0000, pcsrc = 00, irwrite = rdy, pcwrite = rdy.
  - Stay in FETCH while !rdy; go to DECODE when rdy.
- DECODE: alusrcb = 11, aluop = 0000. Next state by op:
  - 100011 / 100001 / 100000 / 100100 / 100101 (loads) → MEMADR
  - 101011 / 101001 / 101000 (stores) → MEMADR
  - 000000 (R-type) → EXEC
  - 000100 / 000101 → BRANCH
  - 001000 / 001001 / 001101 / 001100 / 001010 → IEXEC
  - 000010 → JUMP
  - 010001 with a legal funct → FPEXEC
  - anything else → TRAP
- The op value is registered in DECODE and drives all later decoding; op changing after DECODE has no effect on the current instruction.
- MEMADR: alusrca = 1, alusrcb = 10, aluop = 0000. Go to MEMRD if registered op[3] = 0, else to MEMWR.
- MEMRD: iord = 1; wait for rdy, then MEMWB.
- MEMWB: regwrite = 1, memtoreg = 1, regdst = 0; then FETCH.
- MEMWR: iord = 1, memwrite = 1, held high until rdy; then FETCH.
- EXEC: alusrca = 1, alusrcb = 00, aluop = 1111 (ALU decoder uses funct); then ALUWB.
- ALUWB: regwrite = 1, regdst = 1; then FETCH.
- BRANCH: alusrca = 1, alusrcb = 00, aluop = 0001, branch = 1, pcsrc = 01, ne = op[0]; then FETCH.
- IEXEC: alusrca = 1, alusrcb = 10. aluop by op: ADDI/ADDIU = 0000, ORI = 0011, ANDI = 0111, SLTI = 0110. Then IWB.
- IWB: regwrite = 1, regdst = 0; then FETCH.
- JUMP: pcsrc = 10, pcwrite = 1; then FETCH.
- FPEXEC:
  - fpu_start = 1 only in the first cycle of FPEXEC.
  - fpu_control by funct: 000000 → 0000 (add), 000001 → 0001 (sub), 000010 → 0010 (mul), 000011 → 0011 (div), 000101 → 0100 (abs), 000111 → 0101 (neg). fpu_control is held for the whole state.
  - The timer counts cycles spent in FPEXEC.
  - fpu_done → FPWB. If fpu_done arrives in the first cycle, leave after one cycle.
  - If the timer reaches FPU_TIMEOUT with no fpu_done → TRAP. fpu_done in that same cycle wins.
  - fpu_done outside FPEXEC is ignored.
- FPWB: fp_regwrite = 1; then FETCH.
- TRAP: illegal = 1, all enables 0; stays in TRAP until reset.
- Retirement: instr_done = 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, IWB, JUMP or FPWB. instret increments on the same edge and wraps modulo 2^CNT_W.
- Latency in cycles, with rdy always 1: R-type 4, ADDI 4, beq 3, j 3, lw 5, sw 4, FP op 4 + (cycles until fpu_done).

Test Plan:
- Reset held low for 2 cycles during MEMWR → next cycle state = 0, memwrite = 0, instret = 0, illegal = 0.
- MEM_HANDSHAKE = 1, lw (op = 100011) with mem_ready low for 3 cycles in FETCH and 2 in MEMRD → states 0,0,0,0,1,2,3,3,3,4,0; pcwrite high exactly once; regwrite and memtoreg high only in MEMWB; instr_done pulses once.
- Back-to-back R-type, addi, beq (op = 000100), bne (op = 000101), j with mem_ready = 1 → 4/4/3/3/3 cycles; ne = 0 for beq and 1 for bne; instret = 5 at the end.
- ORI then ANDI → IEXEC aluop = 0011 then 0111; regdst = 0 and regwrite = 1 in IWB.
- op = 010001, funct = 000011, fpu_done asserted 5 cycles after fpu_start → fpu_control = 0011 throughout FPEXEC; fpu_start high exactly 1 cycle; fp_regwrite high 1 cycle.
- FP op with fpu_done never asserted, FPU_TIMEOUT = 8 → TRAP after 8 FPEXEC cycles, illegal stays 1. Separately, op = 111111 → TRAP directly from DECODE; illegal clears only on reset.
